// File: rtl/elevator_group_dispatcher.sv
// elevator_group_dispatcher
//   Hall-call dispatcher for a group of elevator cars. Latches up/down hall
//   presses into call slots, hands each pending call to the cheapest car, and
//   drops a call as soon as any car serves it.
//
//   Optional feature macro: DISPATCH_TIMEOUT_EN
//     When defined, an assigned call left unserved for REASSIGN_TIMEOUT cycles
//     is released. Its next assignment skips the car that let it time out.
//
// Ports
//   clk          system clock
//   reset        synchronous active-high reset
//   hallUp       up-button per floor (top floor bit ignored)
//   hallDown     down-button per floor (bottom floor bit ignored)
//   carFloor     packed floor per car, car c at [c*FW +: FW]
//   carDir       packed direction per car: 00 idle, 01 up, 10 down, 11 idle
//   carDoorOpen  door-open flag per car
//   hallLampUp   pending up calls
//   hallLampDown pending down calls
//   carCallUp    up calls owned by car c at [c*NUM_FLOORS +: NUM_FLOORS]
//   carCallDown  down calls owned by car c, same packing
//
// Dispatch FSM
//   state | meaning
//   IDLE  | no call is waiting for an owner; scan pointer holds
//   SCAN  | some call is unassigned; one slot is evaluated per cycle
module elevator_group_dispatcher #(
  parameter int NUM_CARS         = 3,
  parameter int NUM_FLOORS       = 7,
  parameter int REASSIGN_TIMEOUT = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_FLOORS-1:0]                 hallUp,
  input  logic [NUM_FLOORS-1:0]                 hallDown,
  input  logic [NUM_CARS*$clog2(NUM_FLOORS)-1:0] carFloor,
  input  logic [NUM_CARS*2-1:0]                 carDir,
  input  logic [NUM_CARS-1:0]                   carDoorOpen,
  output logic [NUM_FLOORS-1:0]                 hallLampUp,
  output logic [NUM_FLOORS-1:0]                 hallLampDown,
  output logic [NUM_CARS*NUM_FLOORS-1:0]        carCallUp,
  output logic [NUM_CARS*NUM_FLOORS-1:0]        carCallDown
);

  localparam int FW = $clog2(NUM_FLOORS);
  localparam int CW = FW + 2;
  localparam int OW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int NS = 2 * NUM_FLOORS;
  localparam int PW = $clog2(NS);
  localparam int TW = (REASSIGN_TIMEOUT > 2) ? $clog2(REASSIGN_TIMEOUT) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  if (NUM_CARS < 1 || NUM_CARS > 8) begin : g_bad_cars
    $error("NUM_CARS must be 1..8");
  end
  if (NUM_FLOORS < 2 || NUM_FLOORS > 16) begin : g_bad_floors
    $error("NUM_FLOORS must be 2..16");
  end
  if (REASSIGN_TIMEOUT < 1) begin : g_bad_timeout
    $error("REASSIGN_TIMEOUT must be at least 1");
  end

  // Slot s < NUM_FLOORS is "up at floor s"; slot NUM_FLOORS+f is "down at f".
  logic [NS-1:0]           pend_q, pend_d;
  logic [NS-1:0]           asg_q, asg_d;
  logic [OW-1:0]           owner_q [NS];
  logic [OW-1:0]           owner_d [NS];
`ifdef DISPATCH_TIMEOUT_EN
  logic [TW-1:0]           timer_q [NS];
  logic [TW-1:0]           timer_d [NS];
  logic [OW-1:0]           last_q  [NS];
  logic [OW-1:0]           last_d  [NS];
  logic [NS-1:0]           excl_q, excl_d;
`endif
  logic [0:0]              state_q, state_d;
  logic [PW-1:0]           ptr_q;
  logic [NUM_CARS*NUM_FLOORS-1:0] call_up_q, call_up_d, call_dn_q, call_dn_d;

  logic [NS-1:0]           slot_valid;
  logic [NS-1:0]           press;
  logic [NS-1:0]           clr;
  logic [FW-1:0]           tgt_floor;
  logic [CW-1:0]           cost_c, best_cost;
  logic [OW-1:0]           best_car;

  function automatic logic [CW-1:0] car_cost(input logic [FW-1:0] cf,
                                             input logic [1:0]    dir,
                                             input logic [FW-1:0] tf);
    logic [CW-1:0] d;
    d = (cf > tf) ? CW'(cf - tf) : CW'(tf - cf);
    // A car heading away must turn around first, so it is penalised by a
    // full shaft length.
    if ((dir == 2'b01 && tf < cf) || (dir == 2'b10 && tf > cf))
      d = d + CW'(NUM_FLOORS);
    return d;
  endfunction

  always_comb begin
    slot_valid = '1;
    slot_valid[NUM_FLOORS-1] = 1'b0;
    slot_valid[NUM_FLOORS]   = 1'b0;
    press = {hallDown, hallUp} & slot_valid;
  end

  // A car standing at a floor with its door open serves the hall call in
  // its travel direction; an idle car serves both.
  always_comb begin
    clr = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      for (int c = 0; c < NUM_CARS; c++) begin
        if (carDoorOpen[c] && carFloor[c*FW +: FW] == FW'(f)) begin
          if (carDir[c*2 +: 2] != 2'b10) clr[f] = 1'b1;
          if (carDir[c*2 +: 2] != 2'b01) clr[NUM_FLOORS+f] = 1'b1;
        end
      end
    end
    clr = clr & slot_valid;
  end

  always_comb begin
    tgt_floor = (ptr_q < PW'(NUM_FLOORS)) ? FW'(ptr_q)
                                          : FW'(ptr_q - PW'(NUM_FLOORS));
    best_car  = '0;
    best_cost = '1;
    cost_c    = '0;
    for (int c = 0; c < NUM_CARS; c++) begin
      cost_c = car_cost(carFloor[c*FW +: FW], carDir[c*2 +: 2], tgt_floor);
`ifdef DISPATCH_TIMEOUT_EN
      if (NUM_CARS > 1 && excl_q[ptr_q] && last_q[ptr_q] == OW'(c))
        cost_c = '1;
`endif
      // Strict compare keeps the lowest index on ties, including the case
      // where every car is excluded.
      if (c == 0 || cost_c < best_cost) begin
        best_cost = cost_c;
        best_car  = OW'(c);
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    asg_d   = asg_q;
    owner_d = owner_q;
`ifdef DISPATCH_TIMEOUT_EN
    timer_d = timer_q;
    last_d  = last_q;
    excl_d  = excl_q;
`endif
    for (int s = 0; s < NS; s++) begin
      if (press[s]) pend_d[s] = 1'b1;
      if (state_q == ST_SCAN && ptr_q == PW'(s) && pend_q[s] && !asg_q[s]) begin
        asg_d[s]   = 1'b1;
        owner_d[s] = best_car;
`ifdef DISPATCH_TIMEOUT_EN
        timer_d[s] = '0;
        excl_d[s]  = 1'b0;
      end else if (asg_q[s]) begin
        if (timer_q[s] == TW'(REASSIGN_TIMEOUT - 1)) begin
          asg_d[s]   = 1'b0;
          last_d[s]  = owner_q[s];
          excl_d[s]  = 1'b1;
          timer_d[s] = '0;
        end else begin
          timer_d[s] = timer_q[s] + TW'(1);
        end
`endif
      end
      // Serving beats press, dispatch and timeout in the same cycle.
      if (clr[s]) begin
        pend_d[s] = 1'b0;
        asg_d[s]  = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        timer_d[s] = '0;
        excl_d[s]  = 1'b0;
`endif
      end
    end

    state_d = (|(pend_d & ~asg_d)) ? ST_SCAN : ST_IDLE;

    // Built from next-state values so the car outputs change on the same
    // edge as the lamps.
    call_up_d = '0;
    call_dn_d = '0;
    for (int c = 0; c < NUM_CARS; c++) begin
      for (int f = 0; f < NUM_FLOORS; f++) begin
        call_up_d[c*NUM_FLOORS+f] = pend_d[f] & asg_d[f] & (owner_d[f] == OW'(c));
        call_dn_d[c*NUM_FLOORS+f] = pend_d[NUM_FLOORS+f] & asg_d[NUM_FLOORS+f] &
                                    (owner_d[NUM_FLOORS+f] == OW'(c));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      asg_q     <= '0;
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      call_up_q <= '0;
      call_dn_q <= '0;
      for (int s = 0; s < NS; s++) begin
        owner_q[s] <= '0;
`ifdef DISPATCH_TIMEOUT_EN
        timer_q[s] <= '0;
        last_q[s]  <= '0;
`endif
      end
`ifdef DISPATCH_TIMEOUT_EN
      excl_q <= '0;
`endif
    end else begin
      pend_q    <= pend_d;
      asg_q     <= asg_d;
      owner_q   <= owner_d;
      state_q   <= state_d;
      call_up_q <= call_up_d;
      call_dn_q <= call_dn_d;
`ifdef DISPATCH_TIMEOUT_EN
      timer_q <= timer_d;
      last_q  <= last_d;
      excl_q  <= excl_d;
`endif
      if (state_q == ST_SCAN)
        ptr_q <= (ptr_q == PW'(NS - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  assign hallLampUp   = pend_q[NUM_FLOORS-1:0];
  assign hallLampDown = pend_q[NS-1:NUM_FLOORS];
  assign carCallUp    = call_up_q;
  assign carCallDown  = call_dn_q;

endmodule

// File: tb/tb_elevator_group_dispatcher.sv
module tb_elevator_group_dispatcher;

  localparam int NC = 3;
  localparam int NF = 7;
  localparam int FW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NF-1:0]     hallUp, hallDown;
  logic [NC*FW-1:0]  carFloor;
  logic [NC*2-1:0]   carDir;
  logic [NC-1:0]     carDoorOpen;
  logic [NF-1:0]     hallLampUp, hallLampDown;
  logic [NC*NF-1:0]  carCallUp, carCallDown;

  int checks = 0;
  int passed = 0;

  elevator_group_dispatcher #(
    .NUM_CARS(NC), .NUM_FLOORS(NF), .REASSIGN_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .hallUp(hallUp), .hallDown(hallDown),
    .carFloor(carFloor), .carDir(carDir), .carDoorOpen(carDoorOpen),
    .hallLampUp(hallLampUp), .hallLampDown(hallLampDown),
    .carCallUp(carCallUp), .carCallDown(carCallDown)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_car(input int c, input int fl, input logic [1:0] dir, input logic door);
    logic [FW-1:0] f3;
    f3 = fl[FW-1:0];
    carFloor[c*FW +: FW] = f3;
    carDir[c*2 +: 2]     = dir;
    carDoorOpen[c]       = door;
  endtask

  task automatic apply_reset();
    hallUp = '0;
    hallDown = '0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    hallUp = '0; hallDown = '0;
    carFloor = '0; carDir = '0; carDoorOpen = '0;
    reset = 1'b1;
    tick(2);
    checks++; if (hallLampUp !== 7'd0) $display("FAIL reset_lamp_up: got %b want 0", hallLampUp); else passed++;
    checks++; if (hallLampDown !== 7'd0) $display("FAIL reset_lamp_down: got %b want 0", hallLampDown); else passed++;
    checks++; if (carCallUp !== 21'd0) $display("FAIL reset_call_up: got %h want 0", carCallUp); else passed++;
    checks++; if (carCallDown !== 21'd0) $display("FAIL reset_call_down: got %h want 0", carCallDown); else passed++;
    reset = 1'b0;
    tick(3);
    checks++; if ((carCallUp | carCallDown) !== 21'd0) $display("FAIL idle_no_calls: got %h want 0", carCallUp | carCallDown); else passed++;
  endtask

  task automatic test_latch_assign();
    int n;
    apply_reset();
    for (int c = 0; c < NC; c++) set_car(c, 0, 2'b00, 1'b0);
    hallUp[3] = 1'b1;
    tick(1);
    hallUp = '0;
    checks++; if (hallLampUp !== 7'b0001000) $display("FAIL latch_lamp: got %b want 0001000", hallLampUp); else passed++;
    checks++; if (carCallUp !== 21'd0) $display("FAIL latch_not_yet_assigned: got %h want 0", carCallUp); else passed++;
    n = 0;
    while (carCallUp === 21'd0 && n < 14) begin tick(1); n++; end
    checks++; if (carCallUp !== 21'h000008) $display("FAIL assign_tie_car0: got %h want 000008 after %0d cycles", carCallUp, n); else passed++;
    hallUp[3] = 1'b1;
    tick(2);
    hallUp = '0;
    checks++; if (hallLampUp !== 7'b0001000) $display("FAIL repeat_press_lamp: got %b want 0001000", hallLampUp); else passed++;
    checks++; if (carCallUp !== 21'h000008) $display("FAIL repeat_press_owner: got %h want 000008", carCallUp); else passed++;
  endtask

  task automatic test_cost_distance();
    int n;
    apply_reset();
    set_car(0, 0, 2'b00, 1'b0);
    set_car(1, 5, 2'b00, 1'b0);
    set_car(2, 6, 2'b00, 1'b0);
    hallDown[4] = 1'b1;
    tick(1);
    hallDown = '0;
    checks++; if (hallLampDown !== 7'b0010000) $display("FAIL dist_lamp: got %b want 0010000", hallLampDown); else passed++;
    n = 0;
    while (carCallDown === 21'd0 && n < 14) begin tick(1); n++; end
    checks++; if (carCallDown !== (21'd1 << 11)) $display("FAIL dist_car1: got %h want %h", carCallDown, 21'd1 << 11); else passed++;
    checks++; if (carCallUp !== 21'd0) $display("FAIL dist_no_up: got %h want 0", carCallUp); else passed++;
  endtask

  task automatic test_cost_direction_and_serve();
    int n;
    apply_reset();
    set_car(0, 2, 2'b10, 1'b0);
    set_car(1, 5, 2'b00, 1'b0);
    set_car(2, 6, 2'b00, 1'b0);
    hallUp[3] = 1'b1;
    tick(1);
    hallUp = '0;
    n = 0;
    while (carCallUp === 21'd0 && n < 14) begin tick(1); n++; end
    checks++; if (carCallUp !== (21'd1 << 10)) $display("FAIL dir_car1: got %h want %h", carCallUp, 21'd1 << 10); else passed++;
    // Car 1 arrives at floor 3 while the button is still being pressed.
    set_car(1, 3, 2'b00, 1'b1);
    hallUp[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (hallLampUp !== 7'd0) $display("FAIL serve_lamp cycle %0d: got %b want 0", i, hallLampUp); else passed++;
      checks++; if (carCallUp !== 21'd0) $display("FAIL serve_call cycle %0d: got %h want 0", i, carCallUp); else passed++;
    end
    hallUp = '0;
    set_car(1, 5, 2'b00, 1'b0);
    hallUp[6] = 1'b1;
    hallDown[0] = 1'b1;
    tick(1);
    hallUp = '0;
    hallDown = '0;
    checks++; if ((hallLampUp | hallLampDown) !== 7'd0) $display("FAIL invalid_slots_lamp: got %b want 0", hallLampUp | hallLampDown); else passed++;
    tick(14);
    checks++; if ((carCallUp | carCallDown) !== 21'd0) $display("FAIL invalid_slots_call: got %h want 0", carCallUp | carCallDown); else passed++;
  endtask

  task automatic test_serve_direction();
    int n;
    apply_reset();
    set_car(0, 2, 2'b01, 1'b0);
    set_car(1, 6, 2'b00, 1'b0);
    set_car(2, 6, 2'b00, 1'b0);
    hallDown[2] = 1'b1;
    tick(1);
    hallDown = '0;
    n = 0;
    while (carCallDown === 21'd0 && n < 14) begin tick(1); n++; end
    checks++; if (carCallDown !== 21'h000004) $display("FAIL sdir_assign: got %h want 000004", carCallDown); else passed++;
    set_car(0, 2, 2'b01, 1'b1);
    tick(1);
    checks++; if (hallLampDown !== 7'b0000100) $display("FAIL sdir_up_car_keeps: got %b want 0000100", hallLampDown); else passed++;
    set_car(0, 2, 2'b10, 1'b1);
    tick(1);
    checks++; if (hallLampDown !== 7'd0) $display("FAIL sdir_down_car_clears: got %b want 0", hallLampDown); else passed++;
    checks++; if (carCallDown !== 21'd0) $display("FAIL sdir_call_clear: got %h want 0", carCallDown); else passed++;
    set_car(0, 2, 2'b00, 1'b0);
  endtask

`ifdef DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    apply_reset();
    set_car(0, 5, 2'b00, 1'b0);
    set_car(1, 0, 2'b00, 1'b0);
    set_car(2, 0, 2'b00, 1'b0);
    hallDown[5] = 1'b1;
    tick(1);
    hallDown = '0;
    n = 0;
    while (carCallDown[5] !== 1'b1 && n < 14) begin tick(1); n++; end
    checks++; if (carCallDown !== 21'h000020) $display("FAIL to_first_owner: got %h want 000020", carCallDown); else passed++;
    n = 0;
    while (carCallDown[5] === 1'b1 && n < 20) begin
      tick(1);
      n++;
      checks++; if (hallLampDown !== 7'b0100000) $display("FAIL to_lamp_hold: got %b want 0100000", hallLampDown); else passed++;
    end
    checks++; if (n !== 8) $display("FAIL to_drop_cycles: got %0d want 8", n); else passed++;
    n = 0;
    while (carCallDown[12] !== 1'b1 && n < 14) begin
      tick(1);
      n++;
      checks++; if (hallLampDown !== 7'b0100000) $display("FAIL to_lamp_rescan: got %b want 0100000", hallLampDown); else passed++;
    end
    checks++; if (carCallDown !== (21'd1 << 12)) $display("FAIL to_second_owner: got %h want %h", carCallDown, 21'd1 << 12); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    apply_reset();
    for (int c = 0; c < NC; c++) set_car(c, 0, 2'b00, 1'b0);
    hallUp[1] = 1'b1;
    hallUp[5] = 1'b1;
    hallDown[4] = 1'b1;
    tick(1);
    hallUp = '0;
    hallDown = '0;
    checks++; if (hallLampUp !== 7'b0100010) $display("FAIL mid_lamp_up: got %b want 0100010", hallLampUp); else passed++;
    checks++; if (hallLampDown !== 7'b0010000) $display("FAIL mid_lamp_down: got %b want 0010000", hallLampDown); else passed++;
    n = 0;
    while ((carCallUp | carCallDown) === 21'd0 && n < 14) begin tick(1); n++; end
    checks++; if ((carCallUp | carCallDown) === 21'd0) $display("FAIL mid_some_assigned: got 0 want nonzero"); else passed++;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if ((hallLampUp | hallLampDown) !== 7'd0) $display("FAIL mid_reset_lamps: got %b want 0", hallLampUp | hallLampDown); else passed++;
    checks++; if ((carCallUp | carCallDown) !== 21'd0) $display("FAIL mid_reset_calls: got %h want 0", carCallUp | carCallDown); else passed++;
    hallDown[2] = 1'b1;
    tick(1);
    hallDown = '0;
    checks++; if (hallLampDown !== 7'b0000100) $display("FAIL post_reset_lamp: got %b want 0000100", hallLampDown); else passed++;
    n = 0;
    while (carCallDown === 21'd0 && n < 14) begin tick(1); n++; end
    checks++; if (carCallDown !== 21'h000004) $display("FAIL post_reset_assign: got %h want 000004", carCallDown); else passed++;
    checks++; if (hallLampUp !== 7'd0) $display("FAIL post_reset_no_old: got %b want 0", hallLampUp); else passed++;
  endtask

  initial begin
    test_reset();
    test_latch_assign();
    test_cost_distance();
    test_cost_direction_and_serve();
    test_serve_direction();
`ifdef DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/elevator_group_dispatcher.md
Name: elevator_group_dispatcher

Overview:
- Parametrised hall-call dispatcher for a group of NUM_CARS elevator cars serving NUM_FLOORS floors.
- Latches up/down hall-button presses and assigns each pending call to the lowest-cost car.
- Clears calls when any car serves them.
- Sits between the hall buttons and the per-car Elevator instances, and replaces the fixed three-car floor-button distribution.

Parameters:
- NUM_CARS, 3, number of cars (1..8).
- NUM_FLOORS, 7, number of floors (2..16); floor 0 is the bottom.
- REASSIGN_TIMEOUT, 64, cycles an assigned call may remain unserved before it is reassigned (only with DISPATCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- hallUp  in  NUM_FLOORS  up-button pulses/levels per floor; bit NUM_FLOORS-1 ignored.
- hallDown  in  NUM_FLOORS  down-button pulses/levels per floor; bit 0 ignored.
- carFloor  in  NUM_CARS*FW  packed current floor per car, with FW = $clog2(NUM_FLOORS); car c occupies [c*FW +: FW].
- carDir  in  NUM_CARS*2  packed direction per car: 00 idle, 01 up, 10 down, 11 treated as idle.
- carDoorOpen  in  NUM_CARS  door-open flag per car.
- hallLampUp  out  NUM_FLOORS  pending up calls.
- hallLampDown  out  NUM_FLOORS  pending down calls.
- carCallUp  out  NUM_CARS*NUM_FLOORS  up calls assigned to car c, at [c*NUM_FLOORS +: NUM_FLOORS].
- carCallDown  out  NUM_CARS*NUM_FLOORS  down calls assigned to car c, same packing.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: all outputs 0; all pending, assigned, owner and timer state 0; scan pointer 0.
- Reset mid-operation drops every call, with no carry-over.

Call slots:
- 2*NUM_FLOORS slots: index f is up at floor f, index NUM_FLOORS+f is down at floor f.
- Invalid slots (up at top floor, down at bottom floor) are never pending.
- Per-slot state: pending, assigned, owner[$clog2(NUM_CARS)], lastOwner, timer.

Latch:
- An asserted hall bit sets pending on the next edge; the lamp follows pending, with 1-cycle latency.
- Repeated presses are idempotent.

Serve/clear:
- Up slot f is cleared when any car c has carFloor==f, carDoorOpen=1 and carDir!=10.
- Down slot f is cleared when any car has carFloor==f, carDoorOpen=1 and carDir!=01.
- Clear resets pending, assigned and timer.
- Clear has priority over a same-cycle press and over same-cycle dispatch.

Dispatch FSM (states IDLE, SCAN):
- IDLE when no slot is pending && !assigned; otherwise SCAN.
- In SCAN, one slot at the scan pointer is evaluated per cycle; the pointer wraps 2*NUM_FLOORS-1 -> 0 and advances every SCAN cycle.
- If the slot is pending && !assigned, the minimum-cost car is chosen and assigned=1, owner=c, timer=0 are written.
- Worst-case assignment latency: 2*NUM_FLOORS cycles after the lamp lights.

Cost (width FW+2, unsigned):
- Base cost is |carFloor - f|.
- Add NUM_FLOORS if the car moves away: dir 01 with f<carFloor, or dir 10 with f>carFloor.
- Ties go to the lowest car index.
- A car excluded by the timeout rule gets cost all-ones. If every car is excluded, the lowest index is used.

Outputs:
- carCallUp/Down[c*NUM_FLOORS+f] = pending & assigned & (owner==c), registered.
- At most one car owns a slot.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- Defined:
  - Each assigned slot's timer increments every cycle.
  - On reaching REASSIGN_TIMEOUT-1 the slot sets assigned=0, lastOwner=owner, timer=0.
  - The next dispatch of that slot excludes lastOwner when NUM_CARS>1; the exclusion is cleared once the slot is reassigned or cleared.
  - Clear on the same cycle as the timeout wins.
- Undefined:
  - No timers or lastOwner registers exist.
  - An assignment persists until the call is served or reset is applied.

Test Plan:
- NUM_CARS=3, NUM_FLOORS=7, all cars at floor 0 idle; pulse hallUp[3] -> hallLampUp[3]=1 next cycle; carCallUp[3] (car 0) =1 within 14 cycles; car 1/2 bits stay 0.
- Cars at 0/5/6 idle; pulse hallDown[4] -> car 1 assigned (carCallDown[7+4]=1), cost 1 vs 4 and 2.
- Car0 at 2 dir 10, car1 at 5 idle, car2 at 6 idle; pulse hallUp[3] -> car 1 assigned (car0 cost 8, car1 cost 2, car2 cost 3).
- With a call assigned to car 1 at floor 3 up, drive car1 floor 3, door open, dir 00 while also pressing hallUp[3] -> lamp and carCallUp clear next cycle and stay 0. Press hallUp[6] and hallDown[0] -> never lit.
- DISPATCH_TIMEOUT_EN, REASSIGN_TIMEOUT=8: assign hallDown[5] to car 0, no car arrives -> carCallDown for car 0 drops after 8 cycles; another car owns it within 14 more cycles; lamp stays 1 throughout.
- Several pending/assigned calls, assert reset for 1 cycle -> all lamps and carCall outputs 0 the next cycle; a new press afterwards is dispatched normally.
